// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: clock-enable and reset controller between the PLL and the computer core.
// Define STEP_COUNTER_EN to count issued enable pulses on step_count_o (saturating).
module cpu_clock_ctrl #(
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned RST_SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked_i,
  input  logic [1:0]           mode_i,
  input  logic                 step_btn_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 halt_req_i,
  output logic                 sys_reset_o,
  output logic                 cpu_clk_en_o,
  output logic [2:0]           state_o,
  output logic [15:0]          step_count_o
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StHalt   = 3'd1,
    StStep   = 3'd2,
    StSlow   = 3'd3,
    StRun    = 3'd4,
    StHalted = 3'd5
  } state_e;

  localparam int unsigned DbWidth = $clog2(DEBOUNCE_CYCLES + 1);

  // Reset: asserted asynchronously, released through a synchroniser.
  logic                       arst_n;
  logic                       core_rst_n;
  logic [RST_SYNC_STAGES-1:0] rst_sync_q;

  assign arst_n = rst_n & pll_locked_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign core_rst_n  = rst_sync_q[RST_SYNC_STAGES-1];
  assign sys_reset_o = ~core_rst_n;

  // Step button: synchroniser, then debounce on the synchronised level.
  logic [1:0]         btn_sync_q;
  logic               btn_level_q, btn_level_d;
  logic [DbWidth-1:0] db_cnt_q, db_cnt_d;
  logic               btn_rise;

  always_comb begin
    btn_level_d = btn_level_q;
    db_cnt_d    = '0;
    if (btn_sync_q[1] != btn_level_q) begin
      if (db_cnt_q == DbWidth'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_d = btn_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign btn_rise = btn_level_d & ~btn_level_q;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      btn_sync_q  <= '0;
      btn_level_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[0], step_btn_i};
      btn_level_q <= btn_level_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // Enable FSM.
  state_e               state_q, state_d;
  state_e               mode_state;
  logic                 en_q, en_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_last;

  // Ratios 0 and 1 both wrap every cycle.
  assign div_last = (div_i == '0) ? '0 : div_i - 1'b1;

  always_comb begin
    mode_state = StHalt;
    case (mode_i)
      2'b00:   mode_state = StHalt;
      2'b01:   mode_state = StStep;
      2'b10:   mode_state = StSlow;
      default: mode_state = StRun;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    div_cnt_d = '0;
    case (state_q)
      StReset:  state_d = mode_state;
      StHalt:   state_d = mode_state;
      StStep: begin
        en_d    = btn_rise;
        state_d = mode_state;
      end
      StSlow: begin
        if (div_cnt_q >= div_last) begin
          en_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
        state_d = mode_state;
      end
      StRun: begin
        en_d    = 1'b1;
        state_d = mode_state;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StReset;
    endcase
    // A halt request wins over any pulse due in the same cycle.
    if (halt_req_i && (state_q inside {StStep, StSlow, StRun})) begin
      state_d = StHalted;
      en_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= StReset;
      en_q      <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign cpu_clk_en_o = en_q;
  assign state_o      = state_q;

`ifdef STEP_COUNTER_EN
  logic [15:0] step_count_q;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      step_count_q <= '0;
    end else if (en_q && (step_count_q != 16'hFFFF)) begin
      step_count_q <= step_count_q + 16'd1;
    end
  end

  assign step_count_o = step_count_q;
`else
  assign step_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl: reset release, RUN/SLOW/STEP enables, halt, lock loss.
module tb_cpu_clock_ctrl;
  localparam int unsigned DW  = 8;
  localparam int          DEB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b1;
  logic [1:0]    mode = 2'b11;
  logic          step_btn = 1'b0;
  logic [DW-1:0] div = 8'd5;
  logic          halt_req = 1'b0;
  logic          sys_reset;
  logic          cpu_clk_en;
  logic [2:0]    state;
  logic [15:0]   step_count;

  int checks = 0;
  int failures = 0;

  cpu_clock_ctrl #(
    .DIV_WIDTH      (DW),
    .DEBOUNCE_CYCLES(DEB),
    .RST_SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked_i(pll_locked),
    .mode_i      (mode),
    .step_btn_i  (step_btn),
    .div_i       (div),
    .halt_req_i  (halt_req),
    .sys_reset_o (sys_reset),
    .cpu_clk_en_o(cpu_clk_en),
    .state_o     (state),
    .step_count_o(step_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one (sample/drive point).
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at a sample point; leaves the FSM in the state selected by mode.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(3);
  endtask

  // Plays alternating button levels (starting high) and counts observed enable pulses.
  // The expectation comes from run lengths: a run of a new level at least DEB long is accepted.
  task automatic run_segments(input int segs[$], output int got, output int exp);
    int acc;
    acc = 0;
    got = 0;
    exp = 0;
    for (int s = 0; s < segs.size(); s++) begin
      int val;
      val = (s % 2 == 0) ? 1 : 0;
      if (val != acc && segs[s] >= DEB) begin
        acc = val;
        if (val == 1) exp++;
      end
      step_btn = (val == 1);
      for (int c = 0; c < segs[s]; c++) begin
        tick(1);
        if (cpu_clk_en === 1'b1) got++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; mode = 2'b11; halt_req = 1'b0; step_btn = 1'b0;
    tick(2);
    checks++;
    if ({sys_reset, cpu_clk_en, state, step_count} !== {1'b1, 1'b0, 3'd0, 16'h0}) begin
      failures++;
      $display("FAIL reset_state: got rst=%b en=%b st=%0d cnt=%0h want rst=1 en=0 st=0 cnt=0",
               sys_reset, cpu_clk_en, state, step_count);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (sys_reset !== 1'b1) begin
      failures++;
      $display("FAIL reset_edge1: got sys_reset=%b want 1", sys_reset);
    end
    tick(1);
    checks++;
    if ({sys_reset, state, cpu_clk_en} !== {1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release: got rst=%b st=%0d en=%b want rst=0 st=0 en=0",
               sys_reset, state, cpu_clk_en);
    end
    tick(1);
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL reset_to_run: got state=%0d want 4", state);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (cpu_clk_en !== 1'b1) begin
        failures++;
        $display("FAIL run_enable: cycle %0d got en=%b want 1", i, cpu_clk_en);
      end
    end
  endtask

  task automatic test_slow();
    for (int it = 0; it < 8; it++) begin
      int d, period, next_due, c, nd;
      if (it == 0) begin
        d = 5; c = 3; nd = 2;
      end else if (it == 1) begin
        d = 0; c = 0; nd = 0;
      end else begin
        d = $urandom_range(1, 9);
        c = (d > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, d - 1) : 0;
        nd = (c > 0) ? $urandom_range(1, d) : 0;
      end
      mode = 2'b00;
      tick(2);
      div = DW'(d);
      mode = 2'b10;
      tick(1);
      checks++;
      if (state !== 3'd3) begin
        failures++;
        $display("FAIL slow_entry: got state=%0d want 3", state);
      end
      period = (d == 0) ? 1 : d;
      next_due = period;
      for (int k = 1; k <= 24; k++) begin
        logic exp_en;
        tick(1);
        exp_en = (k == next_due);
        if (exp_en) next_due += period;
        checks++;
        if (cpu_clk_en !== exp_en) begin
          failures++;
          $display("FAIL slow_pulse: div=%0d k=%0d got en=%b want %b", d, k, cpu_clk_en, exp_en);
        end
        if (c > 0 && k == c) begin
          div = DW'(nd);
          period = nd;
          next_due = (c >= nd - 1) ? c + 1 : nd;
        end
      end
    end
    mode = 2'b00;
    tick(2);
  endtask

  task automatic test_step();
    int got, exp;
    int segs[$];
    mode = 2'b01;
    tick(2);
    for (int sc = 0; sc < 8; sc++) begin
      segs = {};
      case (sc)
        0: segs = {3, 3, 3, 3, 3, 3, 20, 20};
        1: segs = {5, 20};
        2: segs = {7, 20};
        3: segs = {8, 20};
        default: begin
          int n;
          n = 2 * $urandom_range(3, 5);
          for (int i = 0; i < n - 1; i++) segs.push_back($urandom_range(1, 14));
          segs.push_back(20);
        end
      endcase
      run_segments(segs, got, exp);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL step_pulses: scenario %0d got %0d pulses want %0d", sc, got, exp);
      end
    end
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL step_state: got state=%0d want 2", state);
    end
  endtask

  task automatic test_step_mode_switch();
    int got;
    got = 0;
    mode = 2'b00;
    tick(2);
    // An edge accepted in HALT is discarded; a press held across the switch gives nothing.
    step_btn = 1'b1; tick(12);
    step_btn = 1'b0; tick(12);
    step_btn = 1'b1; tick(15);
    mode = 2'b01;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn = 1'b0;
      tick(1);
      if (cpu_clk_en === 1'b1) got++;
    end
    checks++;
    if (got !== 0) begin
      failures++;
      $display("FAIL step_switch: got %0d pulses want 0", got);
    end
  endtask

  task automatic test_halt();
    mode = 2'b11;
    tick(3);
    checks++;
    if ({state, cpu_clk_en} !== {3'd4, 1'b1}) begin
      failures++;
      $display("FAIL halt_pre: got st=%0d en=%b want st=4 en=1", state, cpu_clk_en);
    end
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    mode = 2'b10;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({state, cpu_clk_en} !== {3'd5, 1'b0}) begin
        failures++;
        $display("FAIL halted_sticky: cycle %0d got st=%0d en=%b want st=5 en=0",
                 i, state, cpu_clk_en);
      end
      tick(1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_reset, state, cpu_clk_en} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL rstn_async: got rst=%b st=%0d en=%b want rst=1 st=0 en=0",
               sys_reset, state, cpu_clk_en);
    end
    #1;
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (sys_reset !== 1'b0) begin
      failures++;
      $display("FAIL rstn_release: got sys_reset=%b want 0", sys_reset);
    end
    tick(1);
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL rstn_follow_mode: got state=%0d want 3", state);
    end
    mode = 2'b00;
    tick(1);
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({state, cpu_clk_en} !== {3'd1, 1'b0}) begin
        failures++;
        $display("FAIL halt_mode_ignores_req: got st=%0d en=%b want st=1 en=0",
                 state, cpu_clk_en);
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_lock_drop();
    mode = 2'b11;
    tick(3);
    pll_locked = 1'b0;
    #1;
    checks++;
    if ({sys_reset, cpu_clk_en, state} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL lock_async: got rst=%b en=%b st=%0d want rst=1 en=0 st=0",
               sys_reset, cpu_clk_en, state);
    end
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    checks++;
    if (sys_reset !== 1'b1) begin
      failures++;
      $display("FAIL lock_edge1: got sys_reset=%b want 1", sys_reset);
    end
    tick(1);
    checks++;
    if (sys_reset !== 1'b0) begin
      failures++;
      $display("FAIL lock_release: got sys_reset=%b want 0", sys_reset);
    end
    tick(2);
    checks++;
    if ({state, cpu_clk_en} !== {3'd4, 1'b1}) begin
      failures++;
      $display("FAIL lock_resume: got st=%0d en=%b want st=4 en=1", state, cpu_clk_en);
    end
  endtask

  task automatic test_back_to_back();
    // Halt request in the cycle a SLOW pulse is due: no pulse, HALTED.
    mode = 2'b00;
    tick(2);
    div = 8'd3;
    mode = 2'b10;
    tick(3);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    checks++;
    if ({state, cpu_clk_en} !== {3'd5, 1'b0}) begin
      failures++;
      $display("FAIL halt_vs_pulse: got st=%0d en=%b want st=5 en=0", state, cpu_clk_en);
    end
    mode = 2'b00;
    do_reset();
    // Mode change in the cycle a pulse is due: pulse still issued.
    mode = 2'b10;
    tick(3);
    mode = 2'b00;
    tick(1);
    checks++;
    if ({state, cpu_clk_en} !== {3'd1, 1'b1}) begin
      failures++;
      $display("FAIL mode_vs_pulse: got st=%0d en=%b want st=1 en=1", state, cpu_clk_en);
    end
    tick(1);
    checks++;
    if (cpu_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL mode_vs_pulse_after: got en=%b want 0", cpu_clk_en);
    end
  endtask

  task automatic test_step_counter();
    int got, exp;
    int segs[$];
    mode = 2'b01;
    do_reset();
    segs = {12, 12, 12, 12, 12, 20};
    run_segments(segs, got, exp);
`ifdef STEP_COUNTER_EN
    checks++;
    if (step_count !== 16'(exp)) begin
      failures++;
      $display("FAIL step_count_steps: got %0d want %0d", step_count, exp);
    end
    mode = 2'b11;
    tick(70000);
    checks++;
    if (step_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL step_count_sat: got %0h want ffff", step_count);
    end
`else
    checks++;
    if (step_count !== 16'h0000) begin
      failures++;
      $display("FAIL step_count_tied_step: got %0h want 0", step_count);
    end
    mode = 2'b11;
    tick(200);
    checks++;
    if (step_count !== 16'h0000) begin
      failures++;
      $display("FAIL step_count_tied_run: got %0h want 0", step_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_slow();
    test_step();
    test_step_mode_switch();
    test_halt();
    test_lock_drop();
    test_back_to_back();
    test_step_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
